drum_input_ctrl: RTL and testbench

DRUM_INPUT_CTRL -- requirements
Module: drum_input_ctrl

---
 rtl/drum_pkg.sv | 30 +++
 rtl/pad_debounce.sv | 124 ++++++++++++
 rtl/drum_input_ctrl.sv | 91 +++++++++
 tb/tb_drum_input_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drum_pkg
// Purpose  : Shared definitions for the drum input controller: pad FSM state
//            encoding, default timing constants and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package drum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,   // input stable low
      ST_PRESS_DB   = 2'd1,   // input went high, qualifying the press
      ST_HELD       = 2'd2,   // input stable high
      ST_RELEASE_DB = 2'd3    // input went low, qualifying the release
   } pad_state_e;

   localparam int DEBOUNCE_DEFAULT = 250000;    // 10 ms at 25 MHz
   localparam int LOCKOUT_DEFAULT  = 1250000;   // 50 ms at 25 MHz
   localparam int TICKS_DEFAULT    = 25000000;  // 1 s at 25 MHz
   localparam int SECONDS_MAX      = 59;

   // $clog2 of the parameter, but never narrower than one bit so that a
   // parameter value of 1 still yields a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pad_debounce
// Purpose  : One raw contact: 2-flop synchronizer, 4-state debounce FSM,
//            single-cycle press strobe and optional re-trigger lockout.
// Ports    : clk      - clock
//            reset    - synchronous active-high reset
//            raw_i    - raw asynchronous contact, active-high
//            press_o  - one-cycle strobe on each accepted (not locked) press
// Revision : 1.0 - initial release
// ============================================================================
module pad_debounce
   import drum_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int LOCKOUT_CYCLES  = LOCKOUT_DEFAULT,
   parameter bit LOCKOUT_EN      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic press_o
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int LK_W = cnt_width(LOCKOUT_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

   logic            sync1_q, sync2_q;
   pad_state_e      state_q, state_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [LK_W-1:0] lock_q, lock_d;
   logic            press_q, press_d;
   logic            accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= ST_IDLE;
         db_cnt_q <= '0;
         lock_q   <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         db_cnt_q <= db_cnt_d;
         lock_q   <= lock_d;
         press_q  <= press_d;
      end
   end

   // The counter holds the number of qualifying cycles already seen minus
   // one, so it only has to reach DEBOUNCE_CYCLES-1.
   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync2_q) begin
               state_d  = ST_PRESS_DB;
               db_cnt_d = '0;
            end
         end
         ST_PRESS_DB: begin
            if (!sync2_q) begin
               state_d  = ST_IDLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = ST_HELD;
               db_cnt_d = '0;
               accept   = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!sync2_q) begin
               state_d  = ST_RELEASE_DB;
               db_cnt_d = '0;
            end
         end
         ST_RELEASE_DB: begin
            if (sync2_q) begin
               state_d  = ST_HELD;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = ST_IDLE;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
         end
      endcase
   end

   // A suppressed press still lets the FSM reach HELD; only an emitted
   // strobe reloads the lockout.
   always_comb begin
      press_d = 1'b0;
      lock_d  = '0;
      if (LOCKOUT_EN) begin
         if (accept && (lock_q == '0)) begin
            press_d = 1'b1;
            lock_d  = LK_LOAD;
         end else if (lock_q != '0) begin
            lock_d  = lock_q - 1'b1;
         end
      end else begin
         press_d = accept;
      end
   end

   assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/drum_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : drum_input_ctrl
// Purpose  : Debounced hit strobes for three drum pads plus a run/pause
//            seconds timer (0..59) for the display stage.
// Ports    : clk        - 25 MHz clock
//            reset      - synchronous active-high reset
//            hat_pad, cymbal_pad, tom_pad - raw pad contacts
//            timer_btn  - raw run/pause button
//            timer_clr  - synchronous clear of elapsed seconds
//            hat_hit, cymbal_hit, tom_hit - one-cycle hit strobes
//            seconds_o  - elapsed seconds 0..59
//            running_o  - timer running flag
// Revision : 1.0 - initial release
// ============================================================================
module drum_input_ctrl
   import drum_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int LOCKOUT_CYCLES  = LOCKOUT_DEFAULT,
   parameter int TICKS_PER_SEC   = TICKS_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hat_pad,
   input  logic       cymbal_pad,
   input  logic       tom_pad,
   input  logic       timer_btn,
   input  logic       timer_clr,
   output logic       hat_hit,
   output logic       cymbal_hit,
   output logic       tom_hit,
   output logic [5:0] seconds_o,
   output logic       running_o
);

   localparam int TK_W = cnt_width(TICKS_PER_SEC);
   localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICKS_PER_SEC - 1);
   localparam logic [5:0]      SEC_LAST  = 6'(SECONDS_MAX);

   logic btn_press;

   pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .LOCKOUT_EN(1'b1))
      u_hat    (.clk(clk), .reset(reset), .raw_i(hat_pad),    .press_o(hat_hit));
   pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .LOCKOUT_EN(1'b1))
      u_cymbal (.clk(clk), .reset(reset), .raw_i(cymbal_pad), .press_o(cymbal_hit));
   pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .LOCKOUT_EN(1'b1))
      u_tom    (.clk(clk), .reset(reset), .raw_i(tom_pad),    .press_o(tom_hit));
   // The button toggles on every accepted press, so no lockout there.
   pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .LOCKOUT_EN(1'b0))
      u_btn    (.clk(clk), .reset(reset), .raw_i(timer_btn),  .press_o(btn_press));

   logic            running_q, running_d;
   logic [TK_W-1:0] tick_q, tick_d;
   logic [5:0]      sec_q, sec_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         running_q <= 1'b0;
         tick_q    <= '0;
         sec_q     <= '0;
      end else begin
         running_q <= running_d;
         tick_q    <= tick_d;
         sec_q     <= sec_d;
      end
   end

   // Clear wins over counting but is independent of the run/pause toggle.
   always_comb begin
      running_d = running_q ^ btn_press;
      tick_d    = tick_q;
      sec_d     = sec_q;
      if (timer_clr) begin
         tick_d = '0;
         sec_d  = '0;
      end else if (running_q) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            sec_d  = (sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   assign seconds_o = sec_q;
   assign running_o = running_q;

endmodule
`default_nettype wire

// File: tb/tb_drum_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_input_ctrl
// Purpose  : Self-checking bench for drum_input_ctrl (DEBOUNCE=4, LOCKOUT=10,
//            TICKS=20). A second instance with a long lockout exercises
//            strobe suppression.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_input_ctrl;

   logic       clk = 1'b0;
   logic       rst, hat, cym, tom, btn, clr;
   logic       hat_hit, cymbal_hit, tom_hit, running_o;
   logic [5:0] seconds_o;
   logic       lk_hat_hit, lk_cym_hit, lk_tom_hit, lk_running;
   logic [5:0] lk_seconds;

   always #5 clk = ~clk;

   drum_input_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(10), .TICKS_PER_SEC(20)) dut (
      .clk(clk), .reset(rst), .hat_pad(hat), .cymbal_pad(cym), .tom_pad(tom),
      .timer_btn(btn), .timer_clr(clr), .hat_hit(hat_hit), .cymbal_hit(cymbal_hit),
      .tom_hit(tom_hit), .seconds_o(seconds_o), .running_o(running_o));

   drum_input_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(30), .TICKS_PER_SEC(20)) dut_lk (
      .clk(clk), .reset(rst), .hat_pad(hat), .cymbal_pad(cym), .tom_pad(tom),
      .timer_btn(btn), .timer_clr(clr), .hat_hit(lk_hat_hit), .cymbal_hit(lk_cym_hit),
      .tom_hit(lk_tom_hit), .seconds_o(lk_seconds), .running_o(lk_running));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- pad pulse windows ----------------
   int hcnt[3];
   int hfirst[3];
   int lk_hcnt;

   // Drive mask onto the pads during [s1,s1+l1) and [s2,s2+l2) edge indices;
   // edge index 0 is the first edge that samples the pad high.
   task automatic run_window(input logic [2:0] mask, input int s1, input int l1,
                             input int s2, input int l2, input int win);
      logic       on;
      logic [2:0] hv;
      for (int p = 0; p < 3; p++) begin
         hcnt[p]   = 0;
         hfirst[p] = -1;
      end
      lk_hcnt = 0;
      for (int k = 0; k < win; k++) begin
         on = ((k >= s1) && (k < s1 + l1)) || ((k >= s2) && (k < s2 + l2));
         {tom, cym, hat} = on ? mask : 3'b000;
         @(posedge clk); #1;
         hv = {tom_hit, cymbal_hit, hat_hit};
         for (int p = 0; p < 3; p++) begin
            if (hv[p]) begin
               if (hcnt[p] == 0) hfirst[p] = k;
               hcnt[p]++;
            end
         end
         if (lk_hat_hit) lk_hcnt++;
      end
      {tom, cym, hat} = 3'b000;
   endtask

   typedef struct {
      logic [2:0] mask;      // bit0 hat, bit1 cymbal, bit2 tom
      int         len;       // raw high duration in cycles
      int         exp_cnt;   // strobes per selected pad
      int         exp_first; // edge index of the strobe
   } vec_t;

   vec_t vecs[6];

   // ---------------- timer reference model ----------------
   int mt, ms;
   bit mrun;

   task automatic step(input bit tog, input bit clr_now);
      clr = clr_now;
      @(posedge clk); #1;
      if (clr_now) begin
         mt = 0;
         ms = 0;
      end else if (mrun) begin
         if (mt == 19) begin
            mt = 0;
            ms = (ms == 59) ? 0 : ms + 1;
         end else begin
            mt++;
         end
      end
      if (tog) mrun = !mrun;
      check("running_o", int'(running_o), int'(mrun));
      check("seconds_o", int'(seconds_o), ms);
      clr = 1'b0;
   endtask

   // Button high for 6 edges; the accepted press is registered at edge 6
   // and running_o toggles at edge 7.
   task automatic press_btn(input int clr_at);
      for (int k = 0; k < 14; k++) begin
         btn = (k < 6);
         step(k == 7, k == clr_at);
      end
      btn = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{3'b001, 30, 1, 6};   // long hold -> exactly one strobe
      vecs[1] = '{3'b100, 3,  0, -1};  // short glitch -> nothing
      vecs[2] = '{3'b010, 5,  1, 6};   // shortest accepted press
      vecs[3] = '{3'b010, 4,  0, -1};  // one cycle too short
      vecs[4] = '{3'b111, 10, 1, 6};   // all pads together
      vecs[5] = '{3'b100, 1,  0, -1};  // single-cycle spike

      rst = 1'b1; hat = 1'b0; cym = 1'b0; tom = 1'b0; btn = 1'b0; clr = 1'b0;
      mt = 0; ms = 0; mrun = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset hits", int'({hat_hit, cymbal_hit, tom_hit}), 0);
      check("reset seconds", int'(seconds_o), 0);
      check("reset running", int'(running_o), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // table-driven pad vectors
      for (int v = 0; v < 6; v++) begin
         run_window(vecs[v].mask, 0, vecs[v].len, 1000, 0, 45);
         for (int p = 0; p < 3; p++) begin
            if (vecs[v].mask[p]) begin
               check($sformatf("vec%0d pad%0d count", v, p), hcnt[p], vecs[v].exp_cnt);
               if (vecs[v].exp_cnt > 0)
                  check($sformatf("vec%0d pad%0d latency", v, p), hfirst[p], vecs[v].exp_first);
            end else begin
               check($sformatf("vec%0d pad%0d idle", v, p), hcnt[p], 0);
            end
         end
      end

      // re-press 6 cycles after the first: the release never completes
      run_window(3'b010, 0, 5, 6, 5, 45);
      check("cym 6 apart count", hcnt[1], 1);
      // re-press 15 cycles apart: two strobes, second at edge 21
      run_window(3'b010, 0, 5, 15, 5, 50);
      check("cym 15 apart count", hcnt[1], 2);
      check("cym 15 apart first", hfirst[1], 6);
      // fastest legal repeat (10 apart) against lockout 10 and lockout 30
      run_window(3'b001, 0, 5, 10, 5, 50);
      check("hat 10 apart lockout10", hcnt[0], 2);
      check("hat 10 apart lockout30", lk_hcnt, 1);

      // timer: start, full minute with wrap, stop and hold
      press_btn(-1);
      repeat (1200) step(1'b0, 1'b0);
      press_btn(-1);
      repeat (50) step(1'b0, 1'b0);
      // restart, run to 37 s, clear while running
      press_btn(-1);
      for (int g = 0; (g < 2000) && (ms != 37); g++) step(1'b0, 1'b0);
      check("reached 37 s", ms, 37);
      step(1'b0, 1'b1);
      repeat (25) step(1'b0, 1'b0);
      // clear coinciding with the run/pause toggle
      press_btn(7);
      repeat (10) step(1'b0, 1'b0);
      press_btn(-1);
      repeat (30) step(1'b0, 1'b0);

      // reset during PRESS_DB with the pad held through reset
      tom = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("in-reset hits", int'({hat_hit, cymbal_hit, tom_hit}), 0);
         check("in-reset seconds", int'(seconds_o), 0);
         check("in-reset running", int'(running_o), 0);
      end
      mt = 0; ms = 0; mrun = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         check($sformatf("post-reset tom_hit k%0d", k), int'(tom_hit), (k == 6) ? 1 : 0);
      end
      tom = 1'b0;
      repeat (5) step(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
